id_ex_hazard: RTL and testbench

//   ID/EX pipeline register plus hazard control, directly downstream of the instruction decoder.

---
 rtl/id_ex_hazard.sv | 218 +++++++++++++++++++++
 tb/tb_id_ex_hazard.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard.sv
// ID/EX pipeline register with load-use stall detection, flush bubbles,
// syscall drain/halt sequencing, EX forwarding selects and saturating event counters.
module id_ex_hazard #(
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_wreg,
    input  logic              id_r1_used,
    input  logic              id_r2_used,
    input  logic [7:0]        id_ctrl,
    input  logic              id_syscall,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              flush,
    input  logic              resume,
    input  logic              mem_regwrite,
    input  logic [4:0]        mem_wreg,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_wreg,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_wreg,
    output logic [7:0]        ex_ctrl,
    output logic              ex_syscall,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam int DC_W        = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int MEMTOREG_B  = 6;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic [1:0]        r_state;
    logic [DC_W-1:0]   r_drain_cnt;

    logic              r_ex_valid;
    logic [4:0]        r_ex_rs;
    logic [4:0]        r_ex_rt;
    logic [4:0]        r_ex_wreg;
    logic [7:0]        r_ex_ctrl;
    logic              r_ex_syscall;
    logic [DATA_W-1:0] r_ex_pc;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [DATA_W-1:0] r_ex_imm;

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_run;
    logic              w_src_match;
    logic              w_lu_hazard;
    logic              w_load;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    // EX/MEM result is younger than MEM/WB, so it is checked first.
    function automatic logic [1:0] fwd_sel(
        input logic       src_valid,
        input logic [4:0] src,
        input logic       m_rw,
        input logic [4:0] m_wreg,
        input logic       b_rw,
        input logic [4:0] b_wreg
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src_valid) begin
            if (m_rw && (m_wreg != 5'd0) && (m_wreg == src))
                sel = FWD_MEM;
            else if (b_rw && (b_wreg != 5'd0) && (b_wreg == src))
                sel = FWD_WB;
        end
        return sel;
    endfunction

    assign w_run       = (r_state == ST_RUN);
    assign w_src_match = (id_r1_used && (id_rs == r_ex_wreg)) ||
                         (id_r2_used && (id_rt == r_ex_wreg));
    assign w_lu_hazard = w_run && id_valid && r_ex_valid && r_ex_ctrl[MEMTOREG_B] &&
                         (r_ex_wreg != 5'd0) && w_src_match;

    // Capture a new instruction only in RUN with no redirect and no load-use hazard.
    assign w_load = w_run && !flush && !w_lu_hazard;

    // NOTE: always_comb gives every output a default first, so no path can infer a latch.
    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        w_fwd_a = fwd_sel(r_ex_valid, r_ex_rs, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
        w_fwd_b = fwd_sel(r_ex_valid, r_ex_rt, mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand fields are reset too because EX must read all-zero straight out of reset.
            r_ex_valid   <= 1'b0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_wreg    <= '0;
            r_ex_ctrl    <= '0;
            r_ex_syscall <= 1'b0;
            r_ex_pc      <= '0;
            r_ex_a       <= '0;
            r_ex_b       <= '0;
            r_ex_imm     <= '0;
        end else if (w_load) begin
            r_ex_valid   <= id_valid;
            r_ex_rs      <= id_rs;
            r_ex_rt      <= id_rt;
            r_ex_wreg    <= id_wreg;
            r_ex_ctrl    <= id_ctrl;
            r_ex_syscall <= id_syscall;
            r_ex_pc      <= id_pc;
            r_ex_a       <= id_a;
            r_ex_b       <= id_b;
            r_ex_imm     <= id_imm;
        end else begin
            // Bubble: kill the control side, leave operand fields as they were.
            r_ex_valid   <= 1'b0;
            r_ex_wreg    <= '0;
            r_ex_ctrl    <= '0;
            r_ex_syscall <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_load && id_valid && id_syscall) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DC_W'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt <= DC_W'(1)) begin
                        r_state     <= ST_HALT;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DC_W'(1);
                    end
                end
                ST_HALT: begin
                    if (resume)
                        r_state <= ST_RUN;
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_drain_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_run) begin
            if (flush) begin
                if (r_flush_cnt != '1)
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end else if (w_lu_hazard) begin
                if (r_stall_cnt != '1)
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign id_stall   = !w_run || (w_lu_hazard && !flush);
    assign halted     = (r_state == ST_HALT);

    assign ex_valid   = r_ex_valid;
    assign ex_rs      = r_ex_rs;
    assign ex_rt      = r_ex_rt;
    assign ex_wreg    = r_ex_wreg;
    assign ex_ctrl    = r_ex_ctrl;
    assign ex_syscall = r_ex_syscall;
    assign ex_pc      = r_ex_pc;
    assign ex_a       = r_ex_a;
    assign ex_b       = r_ex_b;
    assign ex_imm     = r_ex_imm;

    assign fwd_a_sel  = w_fwd_a;
    assign fwd_b_sel  = w_fwd_b;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_hazard.sv
// Self-checking bench for id_ex_hazard: directed hazard/flush/syscall sequences,
// a forwarding vector table, counter saturation and randomized traffic against a behavioural model.
module tb_id_ex_hazard;

    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int DC   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_rs, id_rt, id_wreg;
    logic          id_r1_used, id_r2_used;
    logic [7:0]    id_ctrl;
    logic          id_syscall;
    logic [DW-1:0] id_pc, id_a, id_b, id_imm;
    logic          flush, resume;
    logic          mem_regwrite, wb_regwrite;
    logic [4:0]    mem_wreg, wb_wreg;

    logic          id_stall, ex_valid, ex_syscall, halted;
    logic [4:0]    ex_rs, ex_rt, ex_wreg;
    logic [7:0]    ex_ctrl;
    logic [DW-1:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    id_ex_hazard #(.DATA_W(DW), .CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used), .id_ctrl(id_ctrl),
        .id_syscall(id_syscall), .id_pc(id_pc), .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
        .flush(flush), .resume(resume),
        .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
        .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_wreg(ex_wreg), .ex_ctrl(ex_ctrl), .ex_syscall(ex_syscall),
        .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the instruction sitting in EX, the pipe mode and event totals.
    typedef struct {
        logic          valid;
        logic [4:0]    rs, rt, wreg;
        logic [7:0]    ctrl;
        logic          sys;
        logic [DW-1:0] pc, a, b, imm;
    } ex_t;

    typedef enum int {M_RUN, M_DRAIN, M_HALT} mode_t;

    ex_t   m_ex;
    mode_t m_mode;
    int    m_left;
    int    m_stall, m_flush;

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt;
        logic       mem_rw;
        logic [4:0] mem_wr;
        logic       wb_rw;
        logic [4:0] wb_wr;
        logic [1:0] exp_a, exp_b;
    } fwd_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_hazard();
        return (m_mode == M_RUN) && id_valid && m_ex.valid && m_ex.ctrl[6] && (m_ex.wreg != 0) &&
               ((id_r1_used && id_rs == m_ex.wreg) || (id_r2_used && id_rt == m_ex.wreg));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (!m_ex.valid) return 2'b00;
        if (mem_regwrite && mem_wreg != 0 && mem_wreg == src) return 2'b01;
        if (wb_regwrite && wb_wreg != 0 && wb_wreg == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic m_reset();
        m_ex.valid = 0; m_ex.rs = 0; m_ex.rt = 0; m_ex.wreg = 0; m_ex.ctrl = 0; m_ex.sys = 0;
        m_ex.pc = 0; m_ex.a = 0; m_ex.b = 0; m_ex.imm = 0;
        m_mode = M_RUN; m_left = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic m_bubble();
        m_ex.valid = 0; m_ex.ctrl = 0; m_ex.sys = 0; m_ex.wreg = 0;
    endtask

    task automatic m_step();
        if (rst) begin
            m_reset();
            return;
        end
        case (m_mode)
            M_RUN: begin
                if (flush) begin
                    m_bubble(); m_flush = sat_inc(m_flush);
                end else if (m_hazard()) begin
                    m_bubble(); m_stall = sat_inc(m_stall);
                end else begin
                    m_ex.valid = id_valid; m_ex.rs = id_rs; m_ex.rt = id_rt; m_ex.wreg = id_wreg;
                    m_ex.ctrl = id_ctrl; m_ex.sys = id_syscall;
                    m_ex.pc = id_pc; m_ex.a = id_a; m_ex.b = id_b; m_ex.imm = id_imm;
                    if (id_valid && id_syscall) begin
                        m_mode = M_DRAIN; m_left = DC;
                    end
                end
            end
            M_DRAIN: begin
                m_bubble();
                m_left--;
                if (m_left <= 0) m_mode = M_HALT;
            end
            default: begin
                m_bubble();
                if (resume) m_mode = M_RUN;
            end
        endcase
    endtask

    task automatic check_all();
        if (rst) return;
        check("ex_valid", 64'(ex_valid), 64'(m_ex.valid));
        check("ex_ctrl", 64'(ex_ctrl), 64'(m_ex.ctrl));
        check("ex_wreg", 64'(ex_wreg), 64'(m_ex.wreg));
        check("ex_syscall", 64'(ex_syscall), 64'(m_ex.sys));
        if (m_ex.valid) begin
            check("ex_rs", 64'(ex_rs), 64'(m_ex.rs));
            check("ex_rt", 64'(ex_rt), 64'(m_ex.rt));
            check("ex_pc", 64'(ex_pc), 64'(m_ex.pc));
            check("ex_a", 64'(ex_a), 64'(m_ex.a));
            check("ex_b", 64'(ex_b), 64'(m_ex.b));
            check("ex_imm", 64'(ex_imm), 64'(m_ex.imm));
        end
        check("id_stall", 64'(id_stall), 64'((m_mode != M_RUN) || (!flush && m_hazard())));
        check("fwd_a_sel", 64'(fwd_a_sel), 64'(m_fwd(m_ex.rs)));
        check("fwd_b_sel", 64'(fwd_b_sel), 64'(m_fwd(m_ex.rt)));
        check("halted", 64'(halted), 64'(m_mode == M_HALT));
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    endtask

    // Inputs are driven just after the falling edge; outputs are sampled 1 ns later.
    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic advance();
        m_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] wreg, input logic r1, input logic r2,
                         input logic [7:0] ctrl, input logic sys);
        id_valid = v; id_rs = rs; id_rt = rt; id_wreg = wreg;
        id_r1_used = r1; id_r2_used = r2; id_ctrl = ctrl; id_syscall = sys;
        id_pc = DW'($urandom); id_a = DW'($urandom); id_b = DW'($urandom); id_imm = DW'($urandom);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 8'h00, 0);
        flush = 0; resume = 0;
        mem_regwrite = 0; mem_wreg = 0; wb_regwrite = 0; wb_wreg = 0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1;
        advance();
        rst = 0;
    endtask

    localparam logic [7:0] C_LW  = 8'b1100_0000;
    localparam logic [7:0] C_ADD = 8'b1000_0010;

    fwd_vec_t      fv[9];
    logic [DW-1:0] pc_exp;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fv[0] = '{1, 5, 6, 1, 5, 1, 5, 2'b01, 2'b00};
        fv[1] = '{1, 5, 6, 0, 5, 1, 5, 2'b10, 2'b00};
        fv[2] = '{1, 5, 6, 1, 6, 1, 5, 2'b10, 2'b01};
        fv[3] = '{1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00};
        fv[4] = '{1, 7, 7, 0, 7, 1, 7, 2'b10, 2'b10};
        fv[5] = '{1, 3, 4, 1, 4, 0, 3, 2'b00, 2'b01};
        fv[6] = '{1, 3, 4, 1, 9, 1, 9, 2'b00, 2'b00};
        fv[7] = '{0, 5, 5, 1, 5, 1, 5, 2'b00, 2'b00};
        fv[8] = '{1, 9, 5, 0, 9, 1, 5, 2'b00, 2'b10};

        m_reset();
        rst = 1;
        apply_reset();

        // Reset state
        settle();
        check("rst_ex_valid", 64'(ex_valid), 0);
        check("rst_ex_pc", 64'(ex_pc), 0);
        check("rst_id_stall", 64'(id_stall), 0);
        check("rst_fwd_a", 64'(fwd_a_sel), 0);
        check("rst_halted", 64'(halted), 0);
        check("rst_stall_cnt", 64'(stall_cnt), 0);

        // LW $t0 then dependent ADD: one stall cycle, bubble, stall_cnt=1
        drive(1, 29, 0, 8, 1, 0, C_LW, 0); settle(); advance();
        drive(1, 8, 9, 10, 1, 1, C_ADD, 0); settle();
        check("lu_stall", 64'(id_stall), 1);
        advance(); settle();
        check("lu_bubble", 64'(ex_valid), 0);
        check("lu_stall_released", 64'(id_stall), 0);
        check("lu_stall_cnt", 64'(stall_cnt), 1);
        advance(); settle();
        check("lu_add_captured", 64'(ex_rs), 8);

        // Same hazard with flush: flush wins
        apply_reset();
        drive(1, 29, 0, 8, 1, 0, C_LW, 0); settle(); advance();
        drive(1, 8, 9, 10, 1, 1, C_ADD, 0); flush = 1; settle();
        check("flush_no_stall", 64'(id_stall), 0);
        advance(); flush = 0; settle();
        check("flush_bubble", 64'(ex_valid), 0);
        check("flush_cnt_1", 64'(flush_cnt), 1);
        check("flush_stall_cnt_0", 64'(stall_cnt), 0);

        // Load to $0 never stalls
        apply_reset();
        drive(1, 29, 0, 0, 1, 0, C_LW, 0); settle(); advance();
        drive(1, 0, 0, 10, 1, 1, C_ADD, 0); settle();
        check("zero_no_stall", 64'(id_stall), 0);
        advance(); settle();
        check("zero_captured", 64'(ex_valid), 1);

        // Forwarding select table
        apply_reset();
        foreach (fv[i]) begin
            drive(fv[i].valid, fv[i].rs, fv[i].rt, 5'd1, 0, 0, C_ADD, 0);
            mem_regwrite = 0; wb_regwrite = 0;
            settle(); advance();
            mem_regwrite = fv[i].mem_rw; mem_wreg = fv[i].mem_wr;
            wb_regwrite = fv[i].wb_rw; wb_wreg = fv[i].wb_wr;
            settle();
            check($sformatf("fwd_a_vec%0d", i), 64'(fwd_a_sel), 64'(fv[i].exp_a));
            check($sformatf("fwd_b_vec%0d", i), 64'(fwd_b_sel), 64'(fv[i].exp_b));
        end
        idle();

        // Syscall drain and halt, flush ignored while draining, then resume
        apply_reset();
        drive(1, 1, 2, 3, 0, 0, 8'h00, 1); settle(); advance();
        drive(1, 4, 5, 6, 1, 1, 8'h80, 0); flush = 1; settle();
        check("sys_in_ex", 64'(ex_syscall), 1);
        check("drain0_stall", 64'(id_stall), 1);
        check("drain0_halted", 64'(halted), 0);
        advance(); flush = 0; settle();
        check("drain1_stall", 64'(id_stall), 1);
        check("drain1_halted", 64'(halted), 0);
        advance(); settle();
        check("halt_halted", 64'(halted), 1);
        check("halt_stall", 64'(id_stall), 1);
        check("drain_flush_ignored", 64'(flush_cnt), 0);
        advance(); settle();
        check("halt_held", 64'(halted), 1);
        resume = 1; settle(); advance(); resume = 0; settle();
        check("resume_halted", 64'(halted), 0);
        check("resume_stall", 64'(id_stall), 0);
        check("resume_bubble", 64'(ex_valid), 0);
        pc_exp = id_pc;
        advance(); settle();
        check("resume_capture_valid", 64'(ex_valid), 1);
        check("resume_capture_pc", 64'(ex_pc), 64'(pc_exp));

        // Reset while halted
        drive(1, 1, 2, 3, 0, 0, 8'h00, 1); settle(); advance();
        drive(1, 4, 5, 6, 0, 0, C_ADD, 0); settle(); advance(); settle(); advance(); settle();
        check("halt_before_rst", 64'(halted), 1);
        rst = 1; advance(); rst = 0; settle();
        check("rst_halt_halted", 64'(halted), 0);
        check("rst_halt_stall", 64'(id_stall), 0);
        check("rst_halt_ex_valid", 64'(ex_valid), 0);
        check("rst_halt_ex_pc", 64'(ex_pc), 0);
        check("rst_halt_ex_a", 64'(ex_a), 0);
        check("rst_halt_ex_rs", 64'(ex_rs), 0);

        // Stall counter saturation
        apply_reset();
        for (int i = 0; i < CMAX + 5; i++) begin
            drive(1, 29, 0, 8, 1, 0, C_LW, 0); settle(); advance();
            drive(1, 0, 8, 10, 0, 1, C_ADD, 0); settle(); advance();
        end
        settle();
        check("stall_cnt_saturated", 64'(stall_cnt), 64'(CMAX));

        // Randomized traffic against the model
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            drive($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 8'($urandom),
                  $urandom_range(0, 39) == 0);
            flush        = ($urandom_range(0, 7) == 0);
            resume       = ($urandom_range(0, 3) == 0);
            mem_regwrite = 1'($urandom);
            mem_wreg     = 5'($urandom_range(0, 7));
            wb_regwrite  = 1'($urandom);
            wb_wreg      = 5'($urandom_range(0, 7));
            settle();
            advance();
        end
        rst = 0;
        idle();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
